// File: rtl/fifo_unpacker.sv
// rtl/fifo_unpacker.sv - pops wide FIFO words and emits them as narrow valid/ready beats
// The next word is popped in the same cycle the last beat is accepted, so back-to-back words have no bubble.
module fifo_unpacker #(
  parameter int DataWidth = 32,
  parameter int OutWidth  = 8,
  parameter bit MsbFirst  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 empty,
  input  logic [DataWidth-1:0] readData,
  output logic                 readEn,
  input  logic                 flush,
  output logic [OutWidth-1:0]  outData,
  output logic                 outValid,
  output logic                 outLast,
  input  logic                 outReady
);

  localparam int Ratio = DataWidth / OutWidth;
  localparam int CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                 state_q, state_d;
  logic [DataWidth-1:0]   shift_reg_q, shift_reg_d;
  logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [OutWidth-1:0]    out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;

  logic accept;
  logic last_acc;
  logic pop;

  function automatic logic [OutWidth-1:0] head_slice(input logic [DataWidth-1:0] w);
    if (MsbFirst) return w[DataWidth-1 -: OutWidth];
    else          return w[OutWidth-1:0];
  endfunction

  function automatic logic [DataWidth-1:0] advance(input logic [DataWidth-1:0] w);
    if (MsbFirst) return w << OutWidth;
    else          return w >> OutWidth;
  endfunction

  assign accept   = out_valid_q && outReady;
  assign last_acc = accept && out_last_q;
  // Flops are held in reset already, so rst_n only needs to gate the outgoing pop.
  assign pop      = !empty && !flush && (state_q == IDLE || last_acc);
  assign readEn   = pop && rst_n;

  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    beat_cnt_d  = beat_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      beat_cnt_d  = '0;
    end else if (pop) begin
      state_d     = EMIT;
      shift_reg_d = readData;
      beat_cnt_d  = '0;
      out_data_d  = head_slice(readData);
      out_valid_d = 1'b1;
      out_last_d  = (Ratio == 1);
    end else if (last_acc) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      beat_cnt_d  = '0;
    end else if (accept) begin
      beat_cnt_d  = beat_cnt_q + CntW'(1);
      shift_reg_d = advance(shift_reg_q);
      out_data_d  = head_slice(shift_reg_d);
      out_last_d  = (beat_cnt_d == LastCnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_reg_q <= '0;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      beat_cnt_q  <= beat_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign outData  = out_data_q;
  assign outValid = out_valid_q;
  assign outLast  = out_last_q;

endmodule
